// File: rtl/shift_button_ctrl.sv
// Up/down push-button front end for the digit-window shifter: sync, debounce, conflict lockout, 1-clk shift requests.
// Hold-to-repeat is built only when SHIFT_BTN_AUTOREPEAT_EN is defined; otherwise one request per press.
module shift_button_ctrl #(
   parameter int DEBOUNCE_CYCLES    = 16,
   parameter int REPEAT_DELAY_TICKS = 50,
   parameter int REPEAT_RATE_TICKS  = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic lock,
   input  logic btn_up,
   input  logic btn_down,
   output logic shift_up,
   output logic shift_down,
   output logic busy
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT, BLOCKED} state_t;

   state_t          state, state_nxt;
   logic            dir_up, dir_up_nxt;
   logic            fire_up, fire_dn, rep_fire;
   logic            held_lvl, other_lvl;
   // Bit 0 carries the up button, bit 1 the down button.
   logic [1:0]      raw, sync1, sync2, lvl, lvl_q, rise;
   logic [DB_W-1:0] db_cnt [2];

   assign raw = {btn_down, btn_up};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         lvl   <= '0;
         lvl_q <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         lvl_q <= lvl;
         // The counter only runs while the synchronised input disagrees with the accepted level.
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               lvl[i]    <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign rise      = lvl & ~lvl_q;
   assign held_lvl  = dir_up ? lvl[0] : lvl[1];
   assign other_lvl = dir_up ? lvl[1] : lvl[0];

`ifdef SHIFT_BTN_AUTOREPEAT_EN
   localparam int TICK_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS
                                                                      : REPEAT_RATE_TICKS;
   localparam int TICK_W = $clog2(TICK_MAX + 1);
   localparam logic [TICK_W-1:0] TICK_SAT = TICK_W'(TICK_MAX);

   logic [TICK_W-1:0] tick_cnt, tick_inc, tick_limit;
   logic              fire_q;

   assign tick_inc   = (tick_cnt == TICK_SAT) ? tick_cnt : tick_cnt + 1'b1;
   assign tick_limit = (state == DELAY) ? TICK_W'(REPEAT_DELAY_TICKS) : TICK_W'(REPEAT_RATE_TICKS);
   // A tick landing right after a request is skipped so requests never abut.
   assign rep_fire   = tick && !fire_q && (tick_inc == tick_limit);

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         fire_q   <= 1'b0;
      end else begin
         fire_q <= fire_up | fire_dn;
         if (state == IDLE || rep_fire)
            tick_cnt <= '0;
         else if ((state == DELAY || state == REPEAT) && tick && !fire_q)
            tick_cnt <= tick_inc;
      end
   end
`else
   logic unused_repeat;
   assign unused_repeat = tick ^ (REPEAT_DELAY_TICKS != 0) ^ (REPEAT_RATE_TICKS != 0);
   assign rep_fire      = 1'b0;
`endif

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_nxt  = state;
      dir_up_nxt = dir_up;
      fire_up    = 1'b0;
      fire_dn    = 1'b0;
      case (state)
         IDLE: begin
            if (&lvl) begin
               state_nxt = BLOCKED;
            end else if (rise[0]) begin
               fire_up    = 1'b1;
               dir_up_nxt = 1'b1;
               state_nxt  = DELAY;
            end else if (rise[1]) begin
               fire_dn    = 1'b1;
               dir_up_nxt = 1'b0;
               state_nxt  = DELAY;
            end
         end
         DELAY, REPEAT: begin
            if (other_lvl) begin
               state_nxt = BLOCKED;
            end else if (!held_lvl) begin
               state_nxt = IDLE;
            end else if (rep_fire) begin
               fire_up   = dir_up;
               fire_dn   = !dir_up;
               state_nxt = REPEAT;
            end
         end
         BLOCKED: if (lvl == 2'b00) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         dir_up     <= 1'b0;
         shift_up   <= 1'b0;
         shift_down <= 1'b0;
      end else begin
         state      <= state_nxt;
         dir_up     <= dir_up_nxt;
         shift_up   <= fire_up & ~lock;
         shift_down <= fire_dn & ~lock;
      end
   end

   assign busy = (state != IDLE) && (|lvl);

endmodule

// File: tb/tb_shift_button_ctrl.sv
// Self-checking bench for shift_button_ctrl: directed press table, corner sequences, then random
// stimulus against a behavioural model. Honours SHIFT_BTN_AUTOREPEAT_EN like the design.
module tb_shift_button_ctrl;
   localparam int DB = 16, DLY = 50, RATE = 10, TICK_GAP = 5, RAND_CYCLES = 20000;
`ifdef SHIFT_BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, tick, lock, btn_up, btn_down;
   logic shift_up, shift_down, busy;

   int checks = 0, failures = 0;
   int tot_up = 0, tot_dn = 0, overlap = 0, wide = 0;
   logic prev_up = 1'b0, prev_dn = 1'b0;

   shift_button_ctrl #(
      .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY_TICKS(DLY), .REPEAT_RATE_TICKS(RATE)
   ) dut (
      .clk(clk), .rst(rst), .tick(tick), .lock(lock), .btn_up(btn_up), .btn_down(btn_down),
      .shift_up(shift_up), .shift_down(shift_down), .busy(busy)
   );

   always #5 clk = ~clk;

   // Pulse bookkeeping sampled mid-cycle.
   always @(negedge clk) begin
      if (shift_up) tot_up <= tot_up + 1;
      if (shift_down) tot_dn <= tot_dn + 1;
      if (shift_up && shift_down) overlap <= overlap + 1;
      if ((shift_up && prev_up) || (shift_down && prev_dn)) wide <= wide + 1;
      prev_up <= shift_up;
      prev_dn <= shift_down;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_ticks(input int n);
      repeat (n) begin
         tick = 1'b1;
         step(1);
         tick = 1'b0;
         step(TICK_GAP - 1);
      end
   endtask

   // Behavioural model: debounced level = last DB synchronised samples all agree; repeat timing
   // from the count of ticks held since the press.
   typedef enum {M_IDLE, M_HELD, M_BLOCK} mmode_t;
   mmode_t     m_mode;
   logic [1:0] m_hist [DB+2];
   logic [1:0] m_lvl, m_lvl_d;
   int         m_dir, m_ticks;
   bit         m_fire_prev;
   logic       exp_up, exp_dn, exp_busy;

   task automatic model_step(input logic r, input logic tk, input logic lk, input logic [1:0] raw);
      logic [1:0] e, fire;
      bit same;
      if (r) begin
         m_mode = M_IDLE; m_lvl = '0; m_lvl_d = '0; m_dir = 0; m_ticks = 0; m_fire_prev = 0;
         for (int i = 0; i < DB + 2; i++) m_hist[i] = '0;
         exp_up = 0; exp_dn = 0; exp_busy = 0;
         return;
      end
      e = m_lvl & ~m_lvl_d;
      fire = '0;
      case (m_mode)
         M_IDLE: begin
            if (m_lvl == 2'b11) m_mode = M_BLOCK;
            else if (e[0]) begin fire[0] = 1; m_dir = 0; m_mode = M_HELD; m_ticks = 0; end
            else if (e[1]) begin fire[1] = 1; m_dir = 1; m_mode = M_HELD; m_ticks = 0; end
         end
         M_HELD: begin
            if (m_lvl[1-m_dir]) m_mode = M_BLOCK;
            else if (!m_lvl[m_dir]) m_mode = M_IDLE;
            else if (AR && tk && !m_fire_prev) begin
               m_ticks++;
               if (m_ticks == DLY || (m_ticks > DLY && (m_ticks - DLY) % RATE == 0)) fire[m_dir] = 1;
            end
         end
         default: if (m_lvl == 2'b00) m_mode = M_IDLE;
      endcase
      m_fire_prev = |fire;
      exp_up = fire[0] & ~lk;
      exp_dn = fire[1] & ~lk;
      for (int i = DB + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = raw;
      m_lvl_d = m_lvl;
      for (int b = 0; b < 2; b++) begin
         same = 1;
         for (int i = 3; i < DB + 2; i++) if (m_hist[i][b] != m_hist[2][b]) same = 0;
         if (same) m_lvl[b] = m_hist[2][b];
      end
      exp_busy = (m_mode != M_IDLE) && (|m_lvl);
   endtask

   typedef struct {
      logic up; logic dn; logic lck; int hold; int exp_up; int exp_dn; logic exp_busy;
   } vec_t;
   vec_t vecs [10];

   initial begin
      int su, sd, lat, first;
      int glitch;
      vecs[0] = '{1'b1, 1'b0, 1'b0, 10,  1,             0,             1'b1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 10,  0,             1,             1'b1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 50,  AR ? 2 : 1,    0,             1'b1};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 49,  0,             1,             1'b1};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 75,  AR ? 4 : 1,    0,             1'b1};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 20,  0,             0,             1'b1};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 0,   1,             0,             1'b1};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 60,  0,             0,             1'b1};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 100, 0,             AR ? 7 : 1,    1'b1};
      vecs[9] = '{1'b1, 1'b0, 1'b0, 200, AR ? 17 : 1,   0,             1'b1};

      rst = 1; tick = 0; lock = 0; btn_up = 1; btn_down = 0;
      // Reset held with the up button pressed.
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("reset_outputs", {29'd0, shift_up, shift_down, busy}, 0);
      end
      rst = 0; btn_up = 0;
      step(30);
      check("no_pulse_after_reset", tot_up + tot_dn, 0);

      // Press latency: first pulse 2+DB+1 clocks after the press is sampled.
      btn_up = 1; lat = -1;
      for (int k = 1; k <= 40; k++) begin
         step(1);
         if (shift_up && lat < 0) lat = k;
      end
      check("press_latency", lat, DB + 3);
      btn_up = 0; step(25);

      // Bouncing press resolves to exactly one request.
      su = tot_up; sd = tot_dn;
      for (int i = 0; i < 12; i++) begin
         btn_up = (i % 2 == 0);
         step(5);
      end
      btn_up = 1; step(40);
      check("bounce_up_count", tot_up - su, 1);
      check("bounce_dn_count", tot_dn - sd, 0);
      btn_up = 0; step(25);

      for (int v = 0; v < 10; v++) begin
         su = tot_up; sd = tot_dn;
         lock = vecs[v].lck; btn_up = vecs[v].up; btn_down = vecs[v].dn;
         step(22);
         do_ticks(vecs[v].hold);
         step(2);
         check($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
         btn_up = 0; btn_down = 0;
         step(25);
         lock = 0;
         check($sformatf("vec%0d_up", v), tot_up - su, vecs[v].exp_up);
         check($sformatf("vec%0d_dn", v), tot_dn - sd, vecs[v].exp_dn);
      end

      // Lock during the press, cleared mid-hold: the first request is lost, the delayed one survives.
      su = tot_up; first = -1;
      lock = 1; btn_up = 1;
      step(22);
      do_ticks(20);
      lock = 0;
      for (int t = 21; t <= 55; t++) begin
         do_ticks(1);
         if (tot_up != su && first < 0) first = t;
      end
      check("lock_first_tick", first, AR ? DLY : -1);
      check("lock_count", tot_up - su, AR ? 1 : 0);
      btn_up = 0; step(25);

      // busy drops 2+DB clocks after release.
      btn_up = 1; step(22); do_ticks(3);
      btn_up = 0; lat = -1;
      for (int k = 1; k <= 40; k++) begin
         step(1);
         if (!busy && lat < 0) lat = k;
      end
      check("busy_fall_latency", lat, DB + 2);
      step(10);

      // Reset mid-hold, then release before the held level can re-debounce.
      btn_up = 1; step(22); do_ticks(5);
      rst = 1; step(1);
      check("rst_hold_outputs", {29'd0, shift_up, shift_down, busy}, 0);
      rst = 0; su = tot_up;
      step(10);
      btn_up = 0; step(30);
      check("rst_hold_no_pulse", tot_up - su, 0);

      // Random phase against the model.
      rst = 1; tick = 0; lock = 0; btn_up = 0; btn_down = 0; glitch = 0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         model_step(rst, tick, lock, {btn_down, btn_up});
         #1;
      end
      rst = 0;
      for (int c = 0; c < RAND_CYCLES; c++) begin
         if (glitch > 0) begin
            glitch--;
            if ($urandom_range(0, 2) == 0) btn_up = ~btn_up;
         end else if ($urandom_range(0, 799) == 0) glitch = $urandom_range(3, 20);
         else if ($urandom_range(0, 249) == 0) btn_up = ~btn_up;
         if ($urandom_range(0, 249) == 0) btn_down = ~btn_down;
         if ($urandom_range(0, 149) == 0) lock = ~lock;
         tick = ($urandom_range(0, 2) == 0);
         rst  = ($urandom_range(0, 2999) == 0);
         @(posedge clk);
         model_step(rst, tick, lock, {btn_down, btn_up});
         #1;
         check("rand_shift_up", shift_up, exp_up);
         check("rand_shift_down", shift_down, exp_dn);
         check("rand_busy", busy, exp_busy);
      end
      rst = 0; tick = 0; btn_up = 0; btn_down = 0;
      step(2);
      check("no_overlap", overlap, 0);
      check("pulse_width_1clk", wide, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
